// File: rtl/sigmoid_backward_pkg.sv
// Shared float32 constants, field helpers and pipeline payload types for the
// sigmoid backward pipeline.
package sigmoid_backward_pkg;

  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  // 1.0 in the 48-bit fixed field used by the 1-s subtractor (binary point below bit 46)
  localparam logic [47:0] ONE_FIX = 48'h4000_0000_0000;

  function automatic logic fp32_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp32_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp32_mant(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (fp32_exp(x) == 8'hFF) && (fp32_mant(x) != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (fp32_exp(x) == 8'hFF) && (fp32_mant(x) == 23'd0);
  endfunction

  // Denormals count as zero: they are flushed before use.
  function automatic logic is_zero(input logic [31:0] x);
    return fp32_exp(x) == 8'h00;
  endfunction

  function automatic logic [31:0] fp32_ftz(input logic [31:0] x);
    return is_zero(x) ? {fp32_sign(x), 31'd0} : x;
  endfunction

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] om;
    logic [31:0] g;
    logic        err;
  } s1_t;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] g;
    logic        err;
  } s2_t;

endpackage

// File: rtl/sigmoid_backward_fp32_mul.sv
// Combinational float32 multiplier: RNE rounding, overflow to Inf, underflow
// below min normal to signed zero, denormal inputs treated as zero.
module fp32_mul
  import sigmoid_backward_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic               sign;
  logic [47:0]        prod;
  logic [22:0]        frac;
  logic               guard;
  logic               sticky;
  logic               up;
  logic [24:0]        rnd;
  logic signed [10:0] exp_r;
  logic signed [10:0] exp_f;

  always_comb begin
    sign = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    up    = guard & (sticky | frac[0]);
    rnd   = {2'b01, frac} + {24'd0, up};
    exp_r = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]})
            - 11'sd127 + $signed({10'd0, prod[47]});
    // a mantissa carry out of rounding leaves rnd[22:0] at zero, so only the exponent moves
    exp_f = exp_r + $signed({10'd0, rnd[24]});
    y     = {sign, exp_f[7:0], rnd[22:0]};

    if (is_nan(a) || is_nan(b))
      y = FP32_QNAN;
    else if (is_inf(a) || is_inf(b))
      y = (is_zero(a) || is_zero(b)) ? FP32_QNAN : {sign, FP32_PINF[30:0]};
    else if (is_zero(a) || is_zero(b))
      y = {sign, 31'd0};
    else if (exp_f >= 11'sd255)
      y = {sign, FP32_PINF[30:0]};
    else if (exp_f <= 11'sd0)
      y = {sign, 31'd0};
  end

endmodule

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass, grad_out = g * s * (1 - s), as a 3-stage float32 pipeline.
// Define SIGMOID_BWD_STATS_EN to add the sat_cnt saturated-sample counter port.
module sigmoid_backward
  import sigmoid_backward_pkg::*;
`ifdef SIGMOID_BWD_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [31:0]      s_in,
  input  logic [31:0]      g_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [31:0]      grad_out,
  output logic             err_out
`ifdef SIGMOID_BWD_STATS_EN
  ,
  output logic [CNT_W-1:0] sat_cnt
`endif
);

  logic        en;
  logic        v1, v2;
  s1_t         s1_d, s1_q;
  s2_t         s2_q;
  logic [31:0] p_d;
  logic [31:0] grad_d;

  logic [7:0]  s_exp, sh;
  logic [47:0] s_al, s_fix, diff, norm;
  logic        s_stk;
  logic [5:0]  lead;
  logic        om_up;
  logic [24:0] om_rnd;
  logic [7:0]  om_exp;
  logic        s_gt_one, s_bad;

  assign en       = !valid_out || ready_out;
  assign ready_in = en;

  // S1: om = 1 - s in a 48-bit fixed field; bits shifted out are jammed into
  // the LSB so the difference keeps an exact sticky for RNE.
  always_comb begin
    s_exp = fp32_exp(s_in);
    sh    = 8'd127 - s_exp;
    s_al  = {2'b01, s_in[22:0], 23'd0};
    if (sh >= 8'd48) begin
      s_fix = '0;
      s_stk = 1'b1;
    end else begin
      s_fix = s_al >> sh;
      s_stk = |(s_al & ((48'd1 << sh) - 48'd1));
    end
    if (is_zero(s_in)) begin
      s_fix = '0;
      s_stk = 1'b0;
    end
    s_fix[0] = s_fix[0] | s_stk;
    diff     = ONE_FIX - s_fix;

    lead = '0;
    for (int i = 0; i < 48; i++)
      if (diff[i]) lead = 6'(i);
    norm   = diff << (6'd46 - lead);
    om_up  = norm[22] & ((|norm[21:0]) | norm[23]);
    om_rnd = {2'b01, norm[45:23]} + {24'd0, om_up};
    om_exp = 8'd81 + {2'b00, lead} + {7'd0, om_rnd[24]};

    s_gt_one = !s_in[31] && ((s_exp > 8'd127) || ((s_exp == 8'd127) && (s_in[22:0] != 23'd0)));
    s_bad    = is_nan(s_in) || (s_in[31] && !is_zero(s_in)) || s_gt_one;

    s1_d.s   = is_zero(s_in) ? 32'd0 : {1'b0, s_in[30:0]};
    s1_d.om  = (diff == '0) ? 32'd0 : {1'b0, om_exp, om_rnd[22:0]};
    s1_d.g   = fp32_ftz(g_in);
    s1_d.err = s_bad;
  end

  fp32_mul u_mul_p (
    .a (s1_q.s),
    .b (s1_q.om),
    .y (p_d)
  );

  fp32_mul u_mul_g (
    .a (s2_q.p),
    .b (s2_q.g),
    .y (grad_d)
  );

`ifdef SIGMOID_BWD_STATS_EN
  logic pz3;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      grad_out  <= 32'd0;
      err_out   <= 1'b0;
`ifdef SIGMOID_BWD_STATS_EN
      pz3       <= 1'b0;
`endif
    end else if (en) begin
      v1        <= valid_in;
      s1_q      <= s1_d;
      v2        <= v1;
      s2_q      <= '{p: p_d, g: s1_q.g, err: s1_q.err};
      valid_out <= v2;
      if (v2) begin
        // inf*0 and NaN g already resolve inside the multiplier since p is never negative
        grad_out <= s2_q.err ? FP32_QNAN : grad_d;
        err_out  <= s2_q.err;
`ifdef SIGMOID_BWD_STATS_EN
        pz3      <= (s2_q.p[30:0] == 31'd0);
`endif
      end
    end
  end

`ifdef SIGMOID_BWD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sat_cnt <= '0;
    else if (valid_out && ready_out && pz3 && !err_out && !(&sat_cnt))
      sat_cnt <= sat_cnt + CNT_W'(1);
  end
`endif

endmodule
